// File: rtl/pwm_meter_pkg.sv
// Shared types, default parameters and the duty helper for the PWM duty meter.
package pwm_meter_pkg;

    localparam int unsigned DUTY_W_DEF      = 3;
    localparam int unsigned WIN_LOG2_DEF    = 10;
    localparam int unsigned SYNC_STAGES_DEF = 2;
    localparam int unsigned GLITCH_CYC_DEF  = 3;

    typedef enum logic [1:0] {
        UNKNOWN = 2'b00,
        RISING  = 2'b01,
        FALLING = 2'b10,
        STEADY  = 2'b11
    } trend_t;

    // A window that is high on every sample would otherwise overflow the code by one.
    function automatic logic [31:0] sat_duty(input logic [31:0]   total,
                                             input int unsigned   win_log2,
                                             input int unsigned   duty_w);
        logic [31:0] full;
        full = 32'd1 << win_log2;
        if (total >= full) begin
            return (32'd1 << duty_w) - 32'd1;
        end
        return total >> (win_log2 - duty_w);
    endfunction

endpackage

// File: rtl/pwm_in_conditioner.sv
// Synchronizes pwm_in, optionally deglitches it (DEGLITCH_EN), and flags level changes.
module pwm_in_conditioner
    import pwm_meter_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int unsigned GLITCH_CYC  = GLITCH_CYC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pwm_in,
    output logic s_q,
    output logic toggle
);

    if (SYNC_STAGES < 2 || GLITCH_CYC < 1) begin : g_bad_cfg
        $error("pwm_in_conditioner: SYNC_STAGES must be >= 2 and GLITCH_CYC >= 1");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   raw;
    logic                   s_cur;
    logic                   prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
        end
    end

    assign raw = sync_q[SYNC_STAGES-1];

`ifdef DEGLITCH_EN
    localparam int unsigned GC_W = $clog2(GLITCH_CYC + 1);

    logic [GC_W-1:0] stable_cnt;
    logic            filt_q;

    // Counts consecutive cycles the raw level disagrees with the accepted level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q     <= 1'b0;
            stable_cnt <= '0;
        end else if (raw == filt_q) begin
            stable_cnt <= '0;
        end else if (stable_cnt == GC_W'(GLITCH_CYC - 1)) begin
            filt_q     <= raw;
            stable_cnt <= '0;
        end else begin
            stable_cnt <= stable_cnt + GC_W'(1);
        end
    end

    assign s_cur = filt_q;
`else
    assign s_cur = raw;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= s_cur;
        end
    end

    assign s_q    = s_cur;
    assign toggle = s_cur ^ prev_q;

endmodule

// File: rtl/pwm_duty_meter.sv
// Recovers duty code, fade trend and stuck status from a PWM line per 2^WIN_LOG2 window.
// Optional input deglitch enabled by defining DEGLITCH_EN.
module pwm_duty_meter
    import pwm_meter_pkg::*;
#(
    parameter int unsigned DUTY_W      = DUTY_W_DEF,
    parameter int unsigned WIN_LOG2    = WIN_LOG2_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int unsigned GLITCH_CYC  = GLITCH_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pwm_in,
    output logic [DUTY_W-1:0] duty,
    output logic              duty_valid,
    output logic [1:0]        trend,
    output logic              stuck_hi,
    output logic              stuck_lo
);

    if (WIN_LOG2 < DUTY_W) begin : g_bad_cfg
        $error("pwm_duty_meter: WIN_LOG2 must be >= DUTY_W");
    end

    logic                s_q;
    logic                toggle;
    logic [WIN_LOG2-1:0] win_cnt;
    logic [WIN_LOG2:0]   high_cnt;
    logic [WIN_LOG2:0]   total;
    logic                trans_q;
    logic                any_trans;
    logic                win_end;
    logic [DUTY_W-1:0]   duty_new;
    logic [DUTY_W-1:0]   prev_duty;
    logic                prev_valid;
    trend_t              state_q;
    trend_t              state_d;

    pwm_in_conditioner #(
        .SYNC_STAGES (SYNC_STAGES),
        .GLITCH_CYC  (GLITCH_CYC)
    ) u_cond (
        .clk    (clk),
        .rst_n  (rst_n),
        .pwm_in (pwm_in),
        .s_q    (s_q),
        .toggle (toggle)
    );

    assign win_end   = (win_cnt == '1);
    assign total     = high_cnt + (WIN_LOG2 + 1)'(s_q);
    assign any_trans = trans_q | toggle;
    assign duty_new  = DUTY_W'(sat_duty(32'(total), WIN_LOG2, DUTY_W));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt  <= '0;
            high_cnt <= '0;
            trans_q  <= 1'b0;
        end else begin
            win_cnt <= win_cnt + WIN_LOG2'(1);
            if (win_end) begin
                high_cnt <= '0;
                trans_q  <= 1'b0;
            end else begin
                high_cnt <= total;
                trans_q  <= any_trans;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty       <= '0;
            duty_valid <= 1'b0;
            stuck_hi   <= 1'b0;
            stuck_lo   <= 1'b0;
            prev_duty  <= '0;
            prev_valid <= 1'b0;
        end else begin
            duty_valid <= win_end;
            if (win_end) begin
                duty       <= duty_new;
                stuck_hi   <= ~any_trans & s_q;
                stuck_lo   <= ~any_trans & ~s_q;
                prev_duty  <= duty_new;
                prev_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= UNKNOWN;
        end else begin
            state_q <= state_d;
        end
    end

    // The first window after reset only seeds prev_duty; trend stays UNKNOWN.
    always_comb begin
        state_d = state_q;
        if (win_end && prev_valid) begin
            if (duty_new > prev_duty) begin
                state_d = RISING;
            end else if (duty_new < prev_duty) begin
                state_d = FALLING;
            end else begin
                state_d = STEADY;
            end
        end
    end

    assign trend = state_q;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Self-checking bench for pwm_duty_meter: window-level model plus directed literal checks.
module tb_pwm_duty_meter;

    localparam int DW  = 3;
    localparam int WL  = 10;
    localparam int SS  = 2;
    localparam int GC  = 3;
    localparam int WIN = 1 << WL;
    localparam int NLIT = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pwm_in = 1'b0;
    logic [DW-1:0] duty;
    logic          duty_valid;
    logic [1:0]    trend;
    logic          stuck_hi;
    logic          stuck_lo;

    always #5 clk = ~clk;

    pwm_duty_meter #(
        .DUTY_W      (DW),
        .WIN_LOG2    (WL),
        .SYNC_STAGES (SS),
        .GLITCH_CYC  (GC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pwm_in     (pwm_in),
        .duty       (duty),
        .duty_valid (duty_valid),
        .trend      (trend),
        .stuck_hi   (stuck_hi),
        .stuck_lo   (stuck_lo)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Per-window stimulus: 0..8 = highs per 8-cycle period, 9 = first 127 cycles high, 10 = one pulse per 16.
    int pat_tbl [13] = '{8, 8, 8, 4, 4, 3, 5, 3, 7, 9, 10, 5, 4};
    int phase = 0;
    int ecnt  = 0;

    // Hand-computed results for windows 0..11 of the first run.
    int       lit_duty  [NLIT] = '{7, 7, 7, 4, 4, 3, 5, 3, 7, 0, 0, 5};
    bit [1:0] lit_trend [NLIT] = '{2'b00, 2'b11, 2'b11, 2'b10, 2'b11, 2'b10,
                                   2'b01, 2'b10, 2'b01, 2'b10, 2'b11, 2'b01};
    bit       lit_hi    [NLIT] = '{0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    bit       lit_lo    [NLIT] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    function automatic bit pat_val(input int code, input int pos);
        if (code == 9)  return pos < 127;
        if (code == 10) return (pos % 16) == 0;
        return (pos % 8) >= (8 - code);
    endfunction

    function automatic int pat_code(input int w);
        if (phase == 0 && w < 13) return pat_tbl[w];
        return 4;
    endfunction

    // ---------------- behavioural model ----------------
    bit       dq[$];
    bit       filt;
    int       run;
    int       m_pos;
    int       m_high;
    bit       m_trans;
    bit       m_last;
    bit       have_prev;
    int       prev_duty;
    int       e_duty;
    bit       e_valid;
    bit [1:0] e_trend;
    bit       e_hi;
    bit       e_lo;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dq.delete();
            for (int i = 0; i < SS; i++) dq.push_back(1'b0);
            filt = 0; run = 0; m_pos = 0; m_high = 0; m_trans = 0; m_last = 0;
            have_prev = 0; prev_duty = 0;
            e_duty = 0; e_valid = 0; e_trend = 2'b00; e_hi = 0; e_lo = 0;
        end else begin
            bit raw;
            bit samp;
            raw = dq.pop_front();
            dq.push_back(pwm_in);
`ifdef DEGLITCH_EN
            samp = filt;
            if (raw != filt) begin
                run++;
                if (run == GC) begin
                    filt = raw;
                    run  = 0;
                end
            end else begin
                run = 0;
            end
`else
            samp = raw;
`endif
            if (samp != m_last) m_trans = 1;
            m_last  = samp;
            m_high += samp;
            e_valid = 0;
            if (m_pos == WIN - 1) begin
                int d;
                d = (m_high >= WIN) ? (1 << DW) - 1 : m_high / (WIN >> DW);
                if (!have_prev)       e_trend = 2'b00;
                else if (d > prev_duty) e_trend = 2'b01;
                else if (d < prev_duty) e_trend = 2'b10;
                else                  e_trend = 2'b11;
                have_prev = 1;
                prev_duty = d;
                e_duty  = d;
                e_valid = 1;
                e_hi    = !m_trans && samp;
                e_lo    = !m_trans && !samp;
                m_high  = 0;
                m_trans = 0;
                m_pos   = 0;
            end else begin
                m_pos++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            n_tests++;
            if (duty_valid !== e_valid || duty !== DW'(e_duty) || trend !== e_trend ||
                stuck_hi !== e_hi || stuck_lo !== e_lo) begin
                n_fail++;
                $display("FAIL model t=%0t: got v=%b duty=%0d trend=%b hi=%b lo=%b, expected v=%b duty=%0d trend=%b hi=%b lo=%b",
                         $time, duty_valid, duty, trend, stuck_hi, stuck_lo,
                         e_valid, e_duty, e_trend, e_hi, e_lo);
            end
        end
    end

    // ---------------- directed checks ----------------
    task automatic check_lit(input string name, input int ed, input bit [1:0] et,
                             input bit eh, input bit el);
        n_tests++;
        if (duty_valid !== 1'b1 || duty !== DW'(ed) || trend !== et ||
            stuck_hi !== eh || stuck_lo !== el) begin
            n_fail++;
            $display("FAIL %s: got v=%b duty=%0d trend=%b hi=%b lo=%b, expected v=1 duty=%0d trend=%b hi=%b lo=%b",
                     name, duty_valid, duty, trend, stuck_hi, stuck_lo, ed, et, eh, el);
        end
    endtask

    task automatic drive();
        pwm_in = pat_val(pat_code((ecnt + 2) / WIN), (ecnt + 2) % WIN);
    endtask

    initial begin
        int cyc;
        bit seen;
`ifdef DEGLITCH_EN
        lit_trend[10] = 2'b10;
        lit_lo[10]    = 1'b1;
`endif
        pwm_in = 1'b1;
        rst_n  = 1'b0;
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b1;
        ecnt   = 0;
        chk_en = 1'b1;

        while (ecnt != 12 * WIN + 500) begin
            drive();
            @(posedge clk);
            ecnt++;
            @(negedge clk);
            if (ecnt % WIN == 0) begin
                int w;
                w = ecnt / WIN - 1;
`ifdef DEGLITCH_EN
                if (w == 10)
`else
                if (w < NLIT)
`endif
                    check_lit($sformatf("window%0d", w), lit_duty[w], lit_trend[w],
                              lit_hi[w], lit_lo[w]);
            end
        end

        // Asynchronous reset mid-window while duty=5 / RISING are on the outputs.
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({duty, duty_valid, trend, stuck_hi, stuck_lo} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got duty=%0d v=%b trend=%b hi=%b lo=%b, expected all 0",
                     duty, duty_valid, trend, stuck_hi, stuck_lo);
        end

        phase = 1;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        ecnt = 0;
        cyc  = 0;
        seen = 0;
        while (cyc < 2 * WIN && !seen) begin
            drive();
            @(posedge clk);
            ecnt++;
            cyc++;
            @(negedge clk);
            if (duty_valid === 1'b1) seen = 1;
        end
        n_tests++;
        if (!seen || cyc != WIN) begin
            n_fail++;
            $display("FAIL first_valid_latency: got seen=%b after %0d cycles, expected %0d",
                     seen, cyc, WIN);
        end
`ifdef DEGLITCH_EN
        n_tests++;
        if (duty_valid !== 1'b1 || trend !== 2'b00) begin
            n_fail++;
            $display("FAIL after_reset: got v=%b trend=%b, expected v=1 trend=00",
                     duty_valid, trend);
        end
`else
        check_lit("after_reset", 4, 2'b00, 1'b0, 1'b0);
`endif

        repeat (20) begin
            drive();
            @(posedge clk);
            ecnt++;
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
